// File: rtl/scurve_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// scurve_sweep_ctrl
//   Sequencer that steps the single-channel S-curve test engine through a
//   full threshold sweep. The outer loop is the DAC code and the inner loop is
//   the channel. For every point it requests a slow-control reload, runs the
//   engine and forwards the engine data words to the readout FIFO.
//
//   Optional build macro: SCURVE_POINT_HEADER_EN
//     When defined, a header word {chn[5:0], dac[9:0]} is written to the FIFO
//     once per point, between the config handshake and the engine run.
//
// Ports
//   Clk, reset           clock, asynchronous active-high reset
//   Sweep_Start/Stop     start pulse (accepted in IDLE) / abort request
//   Start_DAC, End_DAC   inclusive threshold range, DAC_Step (0 acts as 1)
//   Single_Chn_Mode/Chn  restrict the inner loop to one channel
//   Config_Req/Chn/DAC   slow-control load request, Config_Done ack
//   Test_Start           run level to engine, One_Channel_Done from engine
//   Test_Data(_wr_en)    engine data words
//   Fifo_Data/_wr_en     readout FIFO write port, Fifo_Full status
//   Busy, Sweep_Done     status, one-cycle end-of-sweep pulse
//   Sweep_Error          bit0 config timeout, bit1 FIFO overflow (sticky)
// ---------------------------------------------------------------------------
module scurve_sweep_ctrl #(
  parameter int CHN_MAX     = 63,
  parameter int CFG_TIMEOUT = 50000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Sweep_Start,
  input  logic        Sweep_Stop,
  input  logic [9:0]  Start_DAC,
  input  logic [9:0]  End_DAC,
  input  logic [9:0]  DAC_Step,
  input  logic        Single_Chn_Mode,
  input  logic [5:0]  Single_Chn,
  output logic        Config_Req,
  output logic [5:0]  Config_Chn,
  output logic [9:0]  Config_DAC,
  input  logic        Config_Done,
  output logic        Test_Start,
  input  logic        One_Channel_Done,
  input  logic [15:0] Test_Data,
  input  logic        Test_Data_wr_en,
  output logic [15:0] Fifo_Data,
  output logic        Fifo_wr_en,
  input  logic        Fifo_Full,
  output logic        Busy,
  output logic        Sweep_Done,
  output logic [1:0]  Sweep_Error
);

  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CFG_TIMEOUT - 1);
  localparam logic [5:0]    CHN_LAST = 6'(CHN_MAX);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
`ifdef SCURVE_POINT_HEADER_EN
  localparam logic [2:0] S_HDR  = 3'd2;
`endif
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [5:0]    chn_q, chn_d;
  logic [9:0]    dac_q, dac_d;
  logic          req_q, req_d;
  logic          ts_q, ts_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    err_q, err_d;
  logic          mode_q, mode_d;
  logic [5:0]    schn_q, schn_d;
  logic [9:0]    end_q, end_d;
  logic [9:0]    step_q, step_d;
  logic [15:0]   fd_q, fd_d;
  logic          fw_q, fw_d;

  logic          wrap;
  logic [10:0]   sum;

  // Channel loop wraps after the last channel, or after every point when only
  // one channel is tested. The DAC sum keeps a carry bit so a wrap past 1023
  // ends the sweep instead of restarting at a low code.
  assign wrap = mode_q || (chn_q == CHN_LAST);
  assign sum  = {1'b0, dac_q} + {1'b0, step_q};

  always_comb begin
    state_d = state_q;
    chn_d   = chn_q;
    dac_d   = dac_q;
    req_d   = req_q;
    ts_d    = ts_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    mode_d  = mode_q;
    schn_d  = schn_q;
    end_d   = end_q;
    step_d  = step_q;
    fd_d    = Test_Data;
    fw_d    = Test_Data_wr_en;

    // Overflow is judged on the write actually presented to the FIFO.
    if (fw_q && Fifo_Full) err_d[1] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (Sweep_Start) begin
          state_d = S_CFG;
          dac_d   = Start_DAC;
          chn_d   = Single_Chn_Mode ? Single_Chn : 6'd0;
          mode_d  = Single_Chn_Mode;
          schn_d  = Single_Chn;
          end_d   = End_DAC;
          step_d  = (DAC_Step == 10'd0) ? 10'd1 : DAC_Step;
          err_d   = 2'b00;
          req_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      S_CFG: begin
        // Ack beats a timeout expiring in the same cycle.
        if (Config_Done) begin
          req_d = 1'b0;
`ifdef SCURVE_POINT_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_RUN;
`endif
        end else if (tmo_q == TMO_LAST) begin
          req_d    = 1'b0;
          err_d[0] = 1'b1;
          state_d  = S_FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`ifdef SCURVE_POINT_HEADER_EN
      S_HDR: begin
        // Engine is idle here, so the header cannot collide with its data.
        fw_d    = 1'b1;
        fd_d    = {chn_q, dac_q};
        state_d = S_RUN;
      end
`endif
      S_RUN: begin
        ts_d    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (One_Channel_Done) begin
          ts_d    = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Test_Start has been low for this whole cycle before any restart.
        if (!wrap) begin
          chn_d   = chn_q + 6'd1;
          state_d = S_CFG;
          req_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          chn_d = mode_q ? schn_q : 6'd0;
          if (sum[10] || (sum[9:0] > end_q)) begin
            state_d = S_FIN;
          end else begin
            dac_d   = sum[9:0];
            state_d = S_CFG;
            req_d   = 1'b1;
            tmo_d   = '0;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a concurrent channel-done.
    if (Sweep_Stop && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      req_d   = 1'b0;
      ts_d    = 1'b0;
      state_d = S_FIN;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      chn_q   <= '0;
      dac_q   <= '0;
      req_q   <= 1'b0;
      ts_q    <= 1'b0;
      tmo_q   <= '0;
      err_q   <= '0;
      mode_q  <= 1'b0;
      schn_q  <= '0;
      end_q   <= '0;
      step_q  <= '0;
      fd_q    <= '0;
      fw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      chn_q   <= chn_d;
      dac_q   <= dac_d;
      req_q   <= req_d;
      ts_q    <= ts_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      schn_q  <= schn_d;
      end_q   <= end_d;
      step_q  <= step_d;
      fd_q    <= fd_d;
      fw_q    <= fw_d;
    end
  end

  assign Config_Req  = req_q;
  assign Config_Chn  = chn_q;
  assign Config_DAC  = dac_q;
  assign Test_Start  = ts_q;
  assign Fifo_Data   = fd_q;
  assign Fifo_wr_en  = fw_q;
  assign Busy        = (state_q != S_IDLE);
  assign Sweep_Done  = (state_q == S_FIN);
  assign Sweep_Error = err_q;

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scurve_sweep_ctrl
//   Directed bench for scurve_sweep_ctrl with a loader model (acks two cycles
//   after Config_Req), an engine model (6 words per point, then a done pulse,
//   rearming only after Test_Start drops) and a FIFO-side monitor that checks
//   the one-cycle data latency and any header words.
// ---------------------------------------------------------------------------
module tb_scurve_sweep_ctrl;

`ifdef SCURVE_POINT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        Clk, reset;
  logic        Sweep_Start, Sweep_Stop;
  logic [9:0]  Start_DAC, End_DAC, DAC_Step;
  logic        Single_Chn_Mode;
  logic [5:0]  Single_Chn;
  logic        Config_Req;
  logic [5:0]  Config_Chn;
  logic [9:0]  Config_DAC;
  logic        Config_Done;
  logic        Test_Start;
  logic        One_Channel_Done;
  logic [15:0] Test_Data;
  logic        Test_Data_wr_en;
  logic [15:0] Fifo_Data;
  logic        Fifo_wr_en;
  logic        Fifo_Full;
  logic        Busy, Sweep_Done;
  logic [1:0]  Sweep_Error;

  scurve_sweep_ctrl #(.CHN_MAX(63), .CFG_TIMEOUT(20)) dut (
    .Clk(Clk), .reset(reset),
    .Sweep_Start(Sweep_Start), .Sweep_Stop(Sweep_Stop),
    .Start_DAC(Start_DAC), .End_DAC(End_DAC), .DAC_Step(DAC_Step),
    .Single_Chn_Mode(Single_Chn_Mode), .Single_Chn(Single_Chn),
    .Config_Req(Config_Req), .Config_Chn(Config_Chn), .Config_DAC(Config_DAC),
    .Config_Done(Config_Done), .Test_Start(Test_Start),
    .One_Channel_Done(One_Channel_Done), .Test_Data(Test_Data),
    .Test_Data_wr_en(Test_Data_wr_en), .Fifo_Data(Fifo_Data),
    .Fifo_wr_en(Fifo_wr_en), .Fifo_Full(Fifo_Full), .Busy(Busy),
    .Sweep_Done(Sweep_Done), .Sweep_Error(Sweep_Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int vec = 0;
  int errs = 0;

  // model / monitor state
  bit        ld_en = 1'b1;
  int        ld_cnt = 0;
  bit        eng_busy = 1'b0, eng_armed = 1'b1, eng_hold5 = 1'b0;
  int        eng_cnt = 0;
  logic [15:0] eng_seq = 16'h1000;
  bit        exp_wr = 1'b0;
  logic [15:0] exp_data = '0;
  int hs_cnt = 0, fifo_cnt = 0, hdr_cnt = 0, done_cnt = 0, ocd_cnt = 0;
  int req_hi = 0, ts_cnt = 0, mon_err = 0, done_ocd = 0;
  logic [5:0] hs_chn [256];
  logic [9:0] hs_dac [256];

  always @(negedge Clk) begin
    if (reset) begin
      Config_Done = 1'b0; One_Channel_Done = 1'b0; Test_Data_wr_en = 1'b0;
      ld_cnt = 0; eng_busy = 1'b0; eng_armed = 1'b1; exp_wr = 1'b0;
    end else begin
      // monitor
      if (Fifo_wr_en) fifo_cnt++;
      if (exp_wr) begin
        if (!Fifo_wr_en || Fifo_Data !== exp_data) mon_err++;
      end else if (Fifo_wr_en) begin
        hdr_cnt++;
        if (Fifo_Data !== {Config_Chn, Config_DAC}) mon_err++;
      end
      if (Sweep_Done) begin done_cnt++; done_ocd = ocd_cnt; end
      if (Config_Req) req_hi++;
      if (Test_Start) ts_cnt++;
      // loader
      if (Config_Done) Config_Done = 1'b0;
      else if (Config_Req && ld_en) begin
        if (ld_cnt == 1) begin
          Config_Done = 1'b1; ld_cnt = 0;
          if (hs_cnt < 256) begin hs_chn[hs_cnt] = Config_Chn; hs_dac[hs_cnt] = Config_DAC; end
          hs_cnt++;
        end else ld_cnt++;
      end else ld_cnt = 0;
      // engine
      One_Channel_Done = 1'b0;
      Test_Data_wr_en  = 1'b0;
      if (eng_busy) begin
        if (eng_cnt < 6) begin
          Test_Data = eng_seq; Test_Data_wr_en = 1'b1; eng_seq++; eng_cnt++;
        end else if (!(eng_hold5 && Config_Chn == 6'd5)) begin
          One_Channel_Done = 1'b1; ocd_cnt++; eng_busy = 1'b0; eng_armed = 1'b0;
        end
      end else if (eng_armed && Test_Start) begin
        eng_busy = 1'b1; eng_cnt = 0;
      end else if (!Test_Start) begin
        eng_armed = 1'b1;
      end
      exp_wr = Test_Data_wr_en;
      exp_data = Test_Data;
    end
  end

  task automatic tick();
    @(negedge Clk); #1;
  endtask

  task automatic clear_model();
    hs_cnt = 0; fifo_cnt = 0; hdr_cnt = 0; done_cnt = 0; ocd_cnt = 0;
    req_hi = 0; ts_cnt = 0; mon_err = 0; done_ocd = 0;
    eng_busy = 1'b0; eng_armed = 1'b1;
  endtask

  task automatic start_sweep(input logic [9:0] s, input logic [9:0] e,
                             input logic [9:0] st, input logic m, input logic [5:0] c);
    clear_model();
    Start_DAC = s; End_DAC = e; DAC_Step = st; Single_Chn_Mode = m; Single_Chn = c;
    Sweep_Start = 1'b1;
    tick();
    Sweep_Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    vec++;
    if (done_cnt == 0) begin
      errs++; $display("FAIL %s: no Sweep_Done within %0d cycles", nm, budget);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    tick();
    vec++;
    if ({Config_Req, Config_Chn, Config_DAC, Test_Start, Fifo_Data, Fifo_wr_en,
         Busy, Sweep_Done, Sweep_Error} !== '0) begin
      errs++; $display("FAIL reset_outputs: req=%b chn=%0d dac=%0d ts=%b fd=%h fw=%b busy=%b done=%b err=%b, want all 0",
        Config_Req, Config_Chn, Config_DAC, Test_Start, Fifo_Data, Fifo_wr_en, Busy, Sweep_Done, Sweep_Error);
    end
    reset = 1'b0;
    repeat (2) tick();
    vec++;
    if (Busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_full_sweep();
    int bad = 0;
    start_sweep(10'd100, 10'd104, 10'd2, 1'b0, 6'd0);
    vec++;
    if (Busy !== 1'b1 || Config_Req !== 1'b1 || Config_DAC !== 10'd100 || Config_Chn !== 6'd0) begin
      errs++; $display("FAIL full_first_cfg: busy=%b req=%b dac=%0d chn=%0d want 1 1 100 0",
        Busy, Config_Req, Config_DAC, Config_Chn);
    end
    wait_done(10000, "full_done");
    vec++;
    if (hs_cnt !== 192) begin errs++; $display("FAIL full_hs_cnt: got %0d want 192", hs_cnt); end
    for (int i = 0; i < 192; i++)
      if (hs_chn[i] !== 6'(i % 64) || hs_dac[i] !== 10'(100 + 2 * (i / 64))) bad++;
    vec++;
    if (bad != 0) begin errs++; $display("FAIL full_hs_seq: %0d wrong points, want 0", bad); end
    vec++;
    if (fifo_cnt !== 1152 + 192 * HDR) begin
      errs++; $display("FAIL full_fifo_cnt: got %0d want %0d", fifo_cnt, 1152 + 192 * HDR);
    end
    vec++;
    if (hdr_cnt !== 192 * HDR) begin errs++; $display("FAIL full_hdr_cnt: got %0d want %0d", hdr_cnt, 192 * HDR); end
    vec++;
    if (mon_err !== 0) begin errs++; $display("FAIL full_fifo_data: %0d bad writes, want 0", mon_err); end
    vec++;
    if (done_cnt !== 1) begin errs++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    vec++;
    if (Sweep_Error !== 2'b00) begin errs++; $display("FAIL full_err: got %b want 00", Sweep_Error); end
  endtask

  task automatic test_single_step0();
    start_sweep(10'd10, 10'd12, 10'd0, 1'b1, 6'd17);
    wait_done(1000, "single_done");
    vec++;
    if (hs_cnt !== 3 || hs_chn[0] !== 6'd17 || hs_dac[0] !== 10'd10 || hs_chn[1] !== 6'd17 ||
        hs_dac[1] !== 10'd11 || hs_chn[2] !== 6'd17 || hs_dac[2] !== 10'd12) begin
      errs++; $display("FAIL single_points: cnt=%0d (%0d,%0d)(%0d,%0d)(%0d,%0d) want 3 (17,10)(17,11)(17,12)",
        hs_cnt, hs_chn[0], hs_dac[0], hs_chn[1], hs_dac[1], hs_chn[2], hs_dac[2]);
    end
    vec++;
    if (done_ocd !== 3) begin errs++; $display("FAIL single_done_after: ocd=%0d want 3", done_ocd); end
  endtask

  task automatic one_point(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                           input logic [5:0] c, input string nm);
    start_sweep(s, e, st, 1'b1, c);
    wait_done(1000, nm);
    vec++;
    if (hs_cnt !== 1 || hs_dac[0] !== s || hs_chn[0] !== c) begin
      errs++; $display("FAIL %s: cnt=%0d dac=%0d chn=%0d want 1 %0d %0d", nm, hs_cnt, hs_dac[0], hs_chn[0], s, c);
    end
  endtask

  task automatic test_dac_range();
    one_point(10'd1020, 10'd1023, 10'd7, 6'd3, "ovf_step7");
    one_point(10'd1020, 10'd1023, 10'd1000, 6'd4, "ovf_carry");
    one_point(10'd50, 10'd40, 10'd1, 6'd2, "inverted");
  endtask

  task automatic test_cfg_timeout();
    ld_en = 1'b0;
    start_sweep(10'd5, 10'd6, 10'd1, 1'b0, 6'd0);
    wait_done(200, "tmo_done");
    ld_en = 1'b1;
    vec++;
    if (req_hi !== 20) begin errs++; $display("FAIL tmo_req_cycles: got %0d want 20", req_hi); end
    vec++;
    if (Sweep_Error !== 2'b01) begin errs++; $display("FAIL tmo_err: got %b want 01", Sweep_Error); end
    vec++;
    if (done_cnt !== 1) begin errs++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
    vec++;
    if (ts_cnt !== 0) begin errs++; $display("FAIL tmo_test_start: high %0d cycles want 0", ts_cnt); end
  endtask

  task automatic test_abort();
    int n = 0;
    eng_hold5 = 1'b1;
    start_sweep(10'd200, 10'd300, 10'd1, 1'b0, 6'd0);
    vec++;
    if (Sweep_Error !== 2'b00) begin errs++; $display("FAIL abort_err_clr: got %b want 00", Sweep_Error); end
    while (!(Test_Start && Config_Chn == 6'd5) && n < 2000) begin tick(); n++; end
    repeat (12) tick();
    vec++;
    if (Test_Start !== 1'b1 || done_cnt !== 0) begin
      errs++; $display("FAIL abort_in_wait: ts=%b done=%0d want 1 0", Test_Start, done_cnt);
    end
    Sweep_Stop = 1'b1;
    tick();
    Sweep_Stop = 1'b0;
    vec++;
    if (Test_Start !== 1'b0 || Sweep_Done !== 1'b1 || Config_Req !== 1'b0) begin
      errs++; $display("FAIL abort_stop: ts=%b done=%b req=%b want 0 1 0", Test_Start, Sweep_Done, Config_Req);
    end
    repeat (3) tick();
    vec++;
    if (Busy !== 1'b0 || done_cnt !== 1) begin
      errs++; $display("FAIL abort_idle: busy=%b done=%0d want 0 1", Busy, done_cnt);
    end
    eng_hold5 = 1'b0;
    start_sweep(10'd300, 10'd300, 10'd1, 1'b0, 6'd9);
    wait_done(3000, "restart_done");
    vec++;
    if (hs_cnt !== 64 || hs_chn[0] !== 6'd0 || hs_chn[63] !== 6'd63 || hs_dac[0] !== 10'd300) begin
      errs++; $display("FAIL restart_points: cnt=%0d first=(%0d,%0d) last chn=%0d want 64 (0,300) 63",
        hs_cnt, hs_chn[0], hs_dac[0], hs_chn[63]);
    end
    vec++;
    if (Sweep_Error !== 2'b00 || mon_err !== 0) begin
      errs++; $display("FAIL restart_err: err=%b mon=%0d want 00 0", Sweep_Error, mon_err);
    end
  endtask

  task automatic test_fifo_full();
    Fifo_Full = 1'b1;
    start_sweep(10'd7, 10'd7, 10'd1, 1'b1, 6'd33);
    wait_done(1000, "full_fifo_done");
    Fifo_Full = 1'b0;
    vec++;
    if (fifo_cnt !== 6 + HDR || mon_err !== 0) begin
      errs++; $display("FAIL fifo_full_writes: got %0d bad=%0d want %0d 0", fifo_cnt, mon_err, 6 + HDR);
    end
    vec++;
    if (Sweep_Error !== 2'b10) begin errs++; $display("FAIL fifo_full_err: got %b want 10", Sweep_Error); end
    repeat (10) tick();
    vec++;
    if (Sweep_Error !== 2'b10) begin errs++; $display("FAIL fifo_full_sticky: got %b want 10", Sweep_Error); end
    start_sweep(10'd8, 10'd8, 10'd1, 1'b1, 6'd1);
    vec++;
    if (Sweep_Error !== 2'b00) begin errs++; $display("FAIL fifo_err_clear: got %b want 00", Sweep_Error); end
    wait_done(1000, "fifo_clear_done");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start_sweep(10'd20, 10'd30, 10'd1, 1'b0, 6'd0);
    while (!Test_Start && n < 200) begin tick(); n++; end
    reset = 1'b1;
    #1;
    vec++;
    if (Busy !== 1'b0 || Config_Req !== 1'b0 || Test_Start !== 1'b0 || Config_Chn !== 6'd0 ||
        Config_DAC !== 10'd0 || Fifo_wr_en !== 1'b0 || Sweep_Error !== 2'b00) begin
      errs++; $display("FAIL reset_mid: busy=%b req=%b ts=%b chn=%0d dac=%0d fw=%b err=%b want all 0",
        Busy, Config_Req, Test_Start, Config_Chn, Config_DAC, Fifo_wr_en, Sweep_Error);
    end
    tick();
    reset = 1'b0;
    repeat (10) tick();
    vec++;
    if (done_cnt !== 0 || Busy !== 1'b0) begin
      errs++; $display("FAIL reset_mid_nodone: done=%0d busy=%b want 0 0", done_cnt, Busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    Sweep_Start = 1'b0; Sweep_Stop = 1'b0;
    Start_DAC = '0; End_DAC = '0; DAC_Step = '0;
    Single_Chn_Mode = 1'b0; Single_Chn = '0;
    Config_Done = 1'b0; One_Channel_Done = 1'b0;
    Test_Data = '0; Test_Data_wr_en = 1'b0; Fifo_Full = 1'b0;
    test_reset();
    test_full_sweep();
    test_single_step0();
    test_dac_range();
    test_cfg_timeout();
    test_abort();
    test_fifo_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
